// File: rtl/rgb_fade_seq.sv
// Command-driven RGB fader. It takes a target colour over valid/ready and ramps each
// 8-bit channel one LSB per step tick toward the target. Instant and equal-colour commands skip the ramp.
module rgb_fade_seq #(
  parameter int unsigned TICK_DIV = 27000,
  parameter int unsigned TICK_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_rgb,
  input  logic        cmd_blink,
  input  logic        cmd_instant,
  output logic [23:0] rgb,
  output logic        blink_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, FADE} state_t;

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  state_t             state, state_d;
  logic [TICK_W-1:0]  presc, presc_d;
  logic [23:0]        target, target_d;
  logic [23:0]        rgb_d, stepped;
  logic               blink_d, done_d, busy_d, tick;

  function automatic logic [7:0] step(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign cmd_ready = (state == IDLE) & ~rst;
  assign tick      = (presc == LAST);
  assign stepped   = {step(rgb[23:16], target[23:16]),
                      step(rgb[15:8],  target[15:8]),
                      step(rgb[7:0],   target[7:0])};

  always_comb begin
    state_d  = state;
    presc_d  = presc;
    target_d = target;
    rgb_d    = rgb;
    blink_d  = blink_en;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          target_d = cmd_rgb;
          blink_d  = cmd_blink;
          if (cmd_instant || (cmd_rgb == rgb)) begin
            rgb_d  = cmd_rgb;
            done_d = 1'b1;
          end else begin
            state_d = FADE;
            presc_d = '0;
          end
        end
      end
      FADE: begin
        if (tick) begin
          presc_d = '0;
          rgb_d   = stepped;
          // stepping never overshoots, so equality after the step ends the fade
          if (stepped == target) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc + TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FADE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      target   <= '0;
      rgb      <= '0;
      blink_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      presc    <= presc_d;
      target   <= target_d;
      rgb      <= rgb_d;
      blink_en <= blink_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Directed bench for rgb_fade_seq with TICK_DIV=4, using hand-computed colour and timing expectations.
module tb_rgb_fade_seq;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_blink, cmd_instant;
  logic [23:0] cmd_rgb, rgb;
  logic        blink_en, busy, done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned pulses;

  rgb_fade_seq #(.TICK_DIV(4), .TICK_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rgb(cmd_rgb), .cmd_blink(cmd_blink), .cmd_instant(cmd_instant),
    .rgb(rgb), .blink_en(blink_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] c, input logic b, input logic inst);
    cmd_valid = 1'b1; cmd_rgb = c; cmd_blink = b; cmd_instant = inst;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Runs n cycles, counting done pulses.
  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cyc();
      if (done) pulses++;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rgb = '0; cmd_blink = 1'b0; cmd_instant = 1'b0;
    cyc(); cyc();
    check("rst_rgb", rgb, 24'h0);
    check("rst_blink", {23'b0, blink_en}, 24'h0);
    check("rst_busy", {23'b0, busy}, 24'h0);
    check("rst_done", {23'b0, done}, 24'h0);
    check("rst_ready", {23'b0, cmd_ready}, 24'h0);
    rst = 1'b0; #1;
    check("rel_ready", {23'b0, cmd_ready}, 24'h1);

    // fade up 000000 -> 030201
    send(24'h030201, 1'b1, 1'b0);
    check("up_busy0", {23'b0, busy}, 24'h1);
    check("up_rgb0", rgb, 24'h0);
    check("up_blink", {23'b0, blink_en}, 24'h1);
    check("up_ready0", {23'b0, cmd_ready}, 24'h0);
    pulses = 0;
    run(4);  check("up_rgb4", rgb, 24'h010101);
    run(4);  check("up_rgb8", rgb, 24'h020201);
    run(3);  check("up_rgb11", rgb, 24'h020201);
    check("up_done11", {23'b0, done}, 24'h0);
    run(1);  check("up_rgb12", rgb, 24'h030201);
    check("up_done12", {23'b0, done}, 24'h1);
    check("up_busy12", {23'b0, busy}, 24'h0);
    run(3);  check("up_pulses", pulses, 24'd1);
    check("up_hold", rgb, 24'h030201);

    // mixed fade 050005 -> 020302
    send(24'h050005, 1'b0, 1'b1);
    check("inst_rgb", rgb, 24'h050005);
    check("inst_done", {23'b0, done}, 24'h1);
    send(24'h020302, 1'b0, 1'b0);
    check("mix_busy", {23'b0, busy}, 24'h1);
    pulses = 0;
    run(4);  check("mix_rgb4", rgb, 24'h040104);
    run(4);  check("mix_rgb8", rgb, 24'h030203);
    run(4);  check("mix_rgb12", rgb, 24'h020302);
    check("mix_done12", {23'b0, done}, 24'h1);
    run(8);  check("mix_hold", rgb, 24'h020302);
    check("mix_pulses", pulses, 24'd1);

    // instant and equal-colour commands
    send(24'hFF00FF, 1'b0, 1'b1);
    check("ins_rgb", rgb, 24'hFF00FF);
    check("ins_done", {23'b0, done}, 24'h1);
    check("ins_busy", {23'b0, busy}, 24'h0);
    send(24'hFF00FF, 1'b0, 1'b0);
    check("eq_done", {23'b0, done}, 24'h1);
    check("eq_busy", {23'b0, busy}, 24'h0);
    cyc();
    check("eq_done_low", {23'b0, done}, 24'h0);

    // backpressure: second command held during the fade
    send(24'hFE00FE, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_rgb = 24'hFD00FD; cmd_blink = 1'b1; cmd_instant = 1'b0;
    #1;
    check("bp_ready", {23'b0, cmd_ready}, 24'h0);
    cyc(); cyc(); cyc();
    check("bp_blink", {23'b0, blink_en}, 24'h0);
    check("bp_busy3", {23'b0, busy}, 24'h1);
    cyc();
    check("bp_rgb4", rgb, 24'hFE00FE);
    check("bp_done4", {23'b0, done}, 24'h1);
    check("bp_ready4", {23'b0, cmd_ready}, 24'h1);
    cyc();
    cmd_valid = 1'b0;
    check("bp_acc_busy", {23'b0, busy}, 24'h1);
    check("bp_acc_blink", {23'b0, blink_en}, 24'h1);
    check("bp_acc_done", {23'b0, done}, 24'h0);
    pulses = 0;
    run(4);
    check("bp_rgb_end", rgb, 24'hFD00FD);
    check("bp_pulses", pulses, 24'd1);

    // reset mid-fade 000000 -> 808080
    send(24'h000000, 1'b1, 1'b1);
    send(24'h808080, 1'b1, 1'b0);
    pulses = 0;
    run(256);
    check("rm_half", rgb, 24'h404040);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rm_rgb", rgb, 24'h0);
    check("rm_busy", {23'b0, busy}, 24'h0);
    check("rm_blink", {23'b0, blink_en}, 24'h0);
    run(600);
    check("rm_pulses", pulses, 24'd0);
    check("rm_rgb_after", rgb, 24'h0);
    check("rm_busy_after", {23'b0, busy}, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
